// File: rtl/heap_ctrl_pkg.sv
// Shared types for the heap access controller: FSM states, operation kinds
// and the occupancy counter width.
package heap_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef enum logic {
        INSERT,
        POP
    } op_t;

    // Wide enough for the largest supported OP_LAT (15)
    localparam int LAT_W = 4;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/heap_access_ctrl_if.sv
// Producer, pop-consumer and max_heap signals of the heap access controller.
interface heap_access_ctrl_if #(
    parameter int N_PROD = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int OCC_W = heap_ctrl_pkg::occ_w(DEPTH);

    logic [N_PROD-1:0]        prod_valid;
    logic [N_PROD*DATA_W-1:0] prod_data;
    logic [N_PROD-1:0]        prod_ready;
    logic                     pop_req;
    logic                     pop_ack;
    logic [DATA_W-1:0]        pop_data;
    logic [DATA_W-1:0]        heap_data_in;
    logic                     heap_insert;
    logic                     heap_delete;
    logic [DATA_W-1:0]        heap_data_out;
    logic                     heap_full;
    logic                     heap_empty;
    logic [OCC_W-1:0]         occupancy;
    logic                     busy;
    logic                     count_err;

    modport slave (
        input  prod_valid, prod_data, pop_req, heap_data_out, heap_full, heap_empty,
        output prod_ready, pop_ack, pop_data, heap_data_in, heap_insert, heap_delete,
               occupancy, busy, count_err
    );

    modport master (
        output prod_valid, prod_data, pop_req, heap_data_out, heap_full, heap_empty,
        input  prod_ready, pop_ack, pop_data, heap_data_in, heap_insert, heap_delete,
               occupancy, busy, count_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr, so the
// previous winner has lowest priority.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin : search
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        // Walk from the farthest candidate back to the nearest; the nearest hit wins
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt          = '0;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/heap_access_ctrl.sv
// Sequencer/arbiter sharing the max_heap insert/delete port between N_PROD
// producers and one pop consumer, spacing strobes by the heap latency.
module heap_access_ctrl
    import heap_ctrl_pkg::*;
#(
    parameter int N_PROD = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int OP_LAT = 1
) (
    input logic               clk,
    input logic               reset,
    heap_access_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(N_PROD);
    localparam int OCC_W = occ_w(DEPTH);

    state_t           state, state_nxt;
    op_t              last_op, op_sel;
    logic [LAT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] rr_ptr, gnt_idx;
    logic [N_PROD-1:0] gnt;
    logic             ins_ok, pop_ok, go;

    rr_arbiter #(.N(N_PROD), .IW(IDX_W)) u_arb (
        .req     (bus.prod_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        ins_ok    = (|bus.prod_valid) && !bus.heap_full && (bus.occupancy < OCC_W'(DEPTH));
        pop_ok    = bus.pop_req && !bus.heap_empty;
        // Contested slots alternate; last_op starts at POP so INSERT goes first
        if (ins_ok && pop_ok) op_sel = (last_op == POP) ? INSERT : POP;
        else if (ins_ok)      op_sel = INSERT;
        else                  op_sel = POP;
        go        = (state == IDLE) && (ins_ok || pop_ok);
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (go) state_nxt = ISSUE;
            end
            ISSUE: begin
                cnt_nxt   = LAT_W'(OP_LAT);
                state_nxt = (OP_LAT == 0) ? IDLE : WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt <= LAT_W'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_op          <= POP;
            rr_ptr           <= IDX_W'(N_PROD - 1);
            bus.prod_ready   <= '0;
            bus.pop_ack      <= 1'b0;
            bus.pop_data     <= '0;
            bus.heap_data_in <= '0;
            bus.heap_insert  <= 1'b0;
            bus.heap_delete  <= 1'b0;
            bus.occupancy    <= '0;
            bus.busy         <= 1'b0;
            bus.count_err    <= 1'b0;
        end else begin
            bus.prod_ready  <= '0;
            bus.pop_ack     <= 1'b0;
            bus.heap_insert <= 1'b0;
            bus.heap_delete <= 1'b0;
            bus.busy        <= (state_nxt != IDLE);
            if (go) begin
                last_op <= op_sel;
                if (op_sel == INSERT) begin
                    bus.prod_ready   <= gnt;
                    bus.heap_insert  <= 1'b1;
                    bus.heap_data_in <= bus.prod_data[gnt_idx*DATA_W +: DATA_W];
                    bus.occupancy    <= bus.occupancy + 1'b1;
                    rr_ptr           <= gnt_idx;
                end else begin
                    // Root is captured before the delete strobe removes it
                    bus.heap_delete  <= 1'b1;
                    bus.pop_ack      <= 1'b1;
                    bus.pop_data     <= bus.heap_data_out;
                    bus.occupancy    <= bus.occupancy - 1'b1;
                end
            end
            if (state == IDLE &&
                (((bus.occupancy == '0) != bus.heap_empty) ||
                 ((bus.occupancy == OCC_W'(DEPTH)) != bus.heap_full)))
                bus.count_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_heap_access_ctrl.sv
// Randomized bench for heap_access_ctrl: a behavioural max-heap stands in for
// max_heap, and a transaction-level model predicts every op, grant and pop.
module tb_heap_access_ctrl;

    localparam int N_PROD = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int OP_LAT = 1;
    localparam int PERIOD = OP_LAT + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    heap_access_ctrl_if #(.N_PROD(N_PROD), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    heap_access_ctrl #(.N_PROD(N_PROD), .DATA_W(DATA_W), .DEPTH(DEPTH), .OP_LAT(OP_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural heap: unordered storage, root = maximum
    logic [DATA_W-1:0] hmem [DEPTH];
    int hcnt, hmax_i;

    always_comb begin
        hmax_i = 0;
        for (int i = 1; i < DEPTH; i++)
            if (i < hcnt && hmem[i] > hmem[hmax_i]) hmax_i = i;
    end

    assign bus.heap_data_out = (hcnt > 0) ? hmem[hmax_i] : '0;
    assign bus.heap_empty    = (hcnt == 0);
    assign bus.heap_full     = (hcnt == DEPTH);

    always @(posedge clk or posedge reset) begin
        if (reset) hcnt <= 0;
        else if (bus.heap_insert && hcnt < DEPTH) begin
            hmem[hcnt] <= bus.heap_data_in;
            hcnt       <= hcnt + 1;
        end else if (bus.heap_delete && hcnt > 0) begin
            hmem[hmax_i] <= hmem[hcnt-1];
            hcnt         <= hcnt - 1;
        end
    end

    // Stimulus state and reference model
    logic [DATA_W-1:0] keyq [N_PROD][$];
    int pops_left;
    int ref_q[$];
    int popped[$];
    int gnt_log[$];
    int last_win, last_op_cyc, cyc, n_ins, n_ops;
    bit last_pop;
    int n_chk, n_pass;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic drive();
        for (int i = 0; i < N_PROD; i++) begin
            bus.prod_valid[i] = (keyq[i].size() > 0);
            bus.prod_data[i*DATA_W +: DATA_W] = (keyq[i].size() > 0) ? keyq[i][0] : '0;
        end
        bus.pop_req = (pops_left > 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < N_PROD; i++) keyq[i].delete();
        pops_left = 0;
        drive();
        ref_q.delete();
        last_win    = N_PROD - 1;
        last_pop    = 1'b1;
        last_op_cyc = -1000;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One clock: predict what the controller must do this cycle, compare, then update stimulus
    task automatic step();
        bit ins_ok, pop_ok, exp_op, exp_ins;
        int w, mi, mx;
        logic [3:0] exp_sig;
        @(posedge clk);
        #1;
        cyc++;
        ins_ok  = (bus.prod_valid != '0) && (ref_q.size() < DEPTH);
        pop_ok  = bus.pop_req && (ref_q.size() > 0);
        exp_op  = (ins_ok || pop_ok) && (cyc - last_op_cyc >= PERIOD);
        exp_ins = ins_ok && (!pop_ok || last_pop);
        exp_sig = !exp_op ? 4'b0000 : (exp_ins ? 4'b1001 : 4'b0110);
        chk("ops", {bus.heap_insert, bus.heap_delete, bus.pop_ack, |bus.prod_ready}, exp_sig);
        if (exp_op) begin
            last_op_cyc = cyc;
            last_pop    = !exp_ins;
            n_ops++;
            if (exp_ins) begin
                w = -1;
                for (int k = N_PROD; k >= 1; k--)
                    if (bus.prod_valid[(last_win + k) % N_PROD]) w = (last_win + k) % N_PROD;
                chk("grant", bus.prod_ready, 64'(1) << w);
                chk("ins_key", bus.heap_data_in, keyq[w][0]);
                ref_q.push_back(int'(keyq[w][0]));
                void'(keyq[w].pop_front());
                gnt_log.push_back(w);
                last_win = w;
                n_ins++;
            end else begin
                mi = 0;
                for (int i = 1; i < ref_q.size(); i++) if (ref_q[i] > ref_q[mi]) mi = i;
                mx = ref_q[mi];
                ref_q.delete(mi);
                chk("pop_data", bus.pop_data, mx);
                popped.push_back(int'(bus.pop_data));
                pops_left--;
            end
        end
        chk("occupancy", bus.occupancy, ref_q.size());
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain(input int budget);
        bit pend;
        int b;
        b = budget;
        pend = 1'b1;
        while (pend && b > 0) begin
            step();
            b--;
            pend = (pops_left > 0);
            for (int i = 0; i < N_PROD; i++) if (keyq[i].size() > 0) pend = 1'b1;
        end
        if (pend) chk("drain_timeout", 1, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, bus.prod_ready, 0);
        chk({tag, "_ack"},   bus.pop_ack, 0);
        chk({tag, "_ins"},   bus.heap_insert, 0);
        chk({tag, "_del"},   bus.heap_delete, 0);
        chk({tag, "_din"},   bus.heap_data_in, 0);
        chk({tag, "_pdata"}, bus.pop_data, 0);
        chk({tag, "_occ"},   bus.occupancy, 0);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_cerr"},  bus.count_err, 0);
    endtask

    initial begin
        int base, k;
        n_chk = 0; n_pass = 0; cyc = 0; n_ins = 0; n_ops = 0;
        bus.prod_valid = '0;
        bus.prod_data  = '0;
        bus.pop_req    = 1'b0;
        do_reset();
        chk_reset_vals("rst");

        // Single producer, six keys
        keyq[0] = '{8'd10, 8'd20, 8'd5, 8'd7, 8'd25, 8'd3};
        drive();
        drain(40);
        chk("occ_after6", bus.occupancy, 6);

        // Three pops return the largest keys in order
        popped.delete();
        pops_left = 3;
        drive();
        drain(30);
        chk("pop0", popped.size() > 0 ? popped[0] : -1, 25);
        chk("pop1", popped.size() > 1 ? popped[1] : -1, 20);
        chk("pop2", popped.size() > 2 ? popped[2] : -1, 10);
        chk("occ_after_pop", bus.occupancy, 3);

        // All producers at once: round-robin from producer 0
        do_reset();
        gnt_log.delete();
        keyq[0].push_back(8'd15); keyq[1].push_back(8'd17);
        keyq[2].push_back(8'd2);  keyq[3].push_back(8'd9);
        drive();
        drain(40);
        for (int i = 0; i < N_PROD; i++) chk("rr_order", gnt_log.size() > i ? gnt_log[i] : -1, i);

        // Pop and insert both pending: strict alternation, no starvation
        do_reset();
        for (int i = 0; i < 10; i++) keyq[$urandom_range(0, N_PROD-1)].push_back(DATA_W'($urandom_range(0, 255)));
        pops_left = 10;
        drive();
        base = n_ops;
        drain(100);
        chk("alt_ops", n_ops - base, 20);

        // Fill to capacity, then one pop lets exactly one insert through
        do_reset();
        for (int i = 0; i < 20; i++) keyq[i % N_PROD].push_back(DATA_W'($urandom_range(0, 255)));
        drive();
        run(DEPTH * PERIOD + 10);
        chk("occ_full", bus.occupancy, DEPTH);
        k = n_ins;
        pops_left = 1;
        drive();
        run(3 * PERIOD + 4);
        chk("full_pop", pops_left, 0);
        chk("full_one_ins", n_ins - k, 1);
        chk("occ_refull", bus.occupancy, DEPTH);

        // Pop on empty heap waits for an insert
        do_reset();
        popped.delete();
        pops_left = 1;
        drive();
        run(8);
        chk("empty_no_ack", popped.size(), 0);
        keyq[2].push_back(8'd42);
        drive();
        drain(20);
        chk("empty_pop42", popped.size() > 0 ? popped[0] : -1, 42);
        chk("no_count_err", bus.count_err, 0);

        // Asynchronous reset while waiting on the heap
        do_reset();
        keyq[1].push_back(DATA_W'($urandom_range(0, 255)));
        drive();
        k = 0;
        while (!bus.heap_insert && k < 10) begin
            step();
            k++;
        end
        chk("saw_insert", bus.heap_insert, 1);
        step();
        chk("wait_busy", bus.busy, 1);
        #2 reset = 1'b1;
        #1 chk_reset_vals("async");
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1);
    end

endmodule
